sr04_ranger_ctrl: RTL and testbench
===================================

Name: sr04_ranger_ctrl

Overview:
Sequencer for the HC-SR04 ultrasonic ranging channel (s1_trig/s1_echo). It issues trigger pulses, either on single-shot request or from a periodic auto-schedule, and times the echo pulse at 1 us resolution. It converts the echo width to millimetres and reports timeout and out-of-range faults. It sits between the sensor pins and the top-level display/UART logic, and runs in the clk_1m domain.

Parameters:
TRIG_US, 10, trigger high width in clk_1m cycles
PERIOD_US, 60000, auto-mode trigger-to-trigger period in cycles
WAIT_TO_US, 30000, max cycles from trigger fall to echo rise before err_noecho
ECHO_MAX_US, 38000, echo width at or above which measurement aborts with err_range
HOLDOFF_US, 10000, minimum idle cycles after any measurement ends before the next trigger

Ports:
clk_1m  in  1  1 MHz clock; 1 cycle = 1 us
rst  in  1  asynchronous reset, active-high
en_auto  in  1  level; 1 = periodic ranging every PERIOD_US
req_single  in  1  one-cycle pulse; request one measurement
s1_echo  in  1  sensor echo, asynchronous; 2-flop synchronised internally
s1_trig  out  1  sensor trigger
busy  out  1  high in any state other than IDLE
echo_us  out  16  last valid echo width in us
dist_mm  out  14  last valid distance in mm
meas_vld  out  1  one-cycle pulse when echo_us/dist_mm update
err_noecho  out  1  one-cycle pulse on echo-rise timeout
err_range  out  1  one-cycle pulse on echo width >= ECHO_MAX_US

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, all counters 0, pending request cleared, period timer 0.
- echo_s is s1_echo after 2 flops. Edges are detected on echo_s against its previous value.
- Period timer runs only while en_auto=1. It increments each cycle and, on reaching PERIOD_US-1, wraps to 0 and sets the pending flag. When en_auto=0 the timer is held at 0.
- req_single also sets the pending flag. Pending is a single bit, so multiple requests merge. Pending clears on the IDLE->TRIG transition.
- States:
  - IDLE: if pending and echo_s=0, go to TRIG next cycle. If echo_s=1, stay in IDLE so that a stale echo is never measured.
  - TRIG: s1_trig=1 for exactly TRIG_US cycles, then WAIT.
  - WAIT: count cycles. Echo rise goes to MEAS with the width counter at 1. If the count reaches WAIT_TO_US, pulse err_noecho and go to HOLD.
  - MEAS: width counter increments each cycle echo_s=1. On echo fall, latch the width and go to CONV. If the width reaches ECHO_MAX_US while echo is still high, pulse err_range and go to HOLD. echo_us and dist_mm are not updated in that case.
  - CONV: a single cycle. prod = width*11239 (30-bit unsigned). dist_mm = prod[29:16], the truncated value of width*0.171494. echo_us = width. meas_vld pulses in this cycle. Then go to HOLD.
  - HOLD: count HOLDOFF_US cycles, then IDLE. Requests arriving in HOLD remain pending.
- Latency: meas_vld is asserted 2 cycles after the cycle in which echo_s is first seen low (1 cycle to CONV, with outputs registered at CONV exit).
- In auto mode, if the measurement plus holdoff exceeds PERIOD_US, the next trigger starts on the first IDLE cycle. No requests are lost beyond merging.
- Dropping en_auto mid-measurement completes the current measurement.
- s1_trig is registered and glitch-free.
- Only one of meas_vld, err_noecho, or err_range pulses per trigger.

Test Plan:
1. req_single; model returns echo 1000 us after trigger fall+50 -> s1_trig high exactly 10 cycles; meas_vld once; echo_us=1000; dist_mm=171.
2. req_single with no echo -> err_noecho 30000 cycles after trigger fall; no meas_vld; busy low 10000 cycles later; echo_us/dist_mm keep their previous values.
3. Echo held high 40000 us -> err_range when width hits 38000; outputs unchanged; after holdoff, IDLE waits for echo low before the next trigger.
4. en_auto=1, echo 5800 us -> triggers exactly 60000 cycles apart; each meas_vld gives dist_mm=994; en_auto=0 mid-MEAS -> that measurement completes and no further triggers.
5. req_single pulsed 3 times during MEAS/HOLD -> exactly one extra trigger after holdoff.
6. rst asserted mid-TRIG and mid-MEAS -> s1_trig and all outputs 0 immediately; after release, no trigger until a new req_single.

Source files
------------

// File: rtl/sr04_ranger_ctrl.sv
// HC-SR04 ranging sequencer: issues trigger pulses (single-shot or periodic), times the
// echo at 1 us resolution, converts the width to millimetres and flags timeout/range faults.
module sr04_ranger_ctrl #(
    parameter int unsigned TRIG_US     = 10,
    parameter int unsigned PERIOD_US   = 60000,
    parameter int unsigned WAIT_TO_US  = 30000,
    parameter int unsigned ECHO_MAX_US = 38000,
    parameter int unsigned HOLDOFF_US  = 10000
) (
    input  logic        clk_1m,
    input  logic        rst,
    input  logic        en_auto,
    input  logic        req_single,
    input  logic        s1_echo,
    output logic        s1_trig,
    output logic        busy,
    output logic [15:0] echo_us,
    output logic [13:0] dist_mm,
    output logic        meas_vld,
    output logic        err_noecho,
    output logic        err_range
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_MEAS,
        S_CONV,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] width_q, width_d;
    logic [15:0] period_q, period_d;
    logic        pend_q, pend_d;
    logic        echo_meta_q, echo_s_q, echo_prev_q;
    logic        trig_q, trig_d;
    logic        vld_q, vld_d;
    logic        noecho_q, noecho_d;
    logic        range_q, range_d;
    logic [15:0] echo_us_q, echo_us_d;
    logic [13:0] dist_q, dist_d;
    logic        launch;
    logic        period_wrap;
    logic        echo_rise;

    assign echo_rise = echo_s_q & ~echo_prev_q;

    // Free-running period timer, parked at zero whenever auto mode is off.
    always_comb begin
        period_d    = '0;
        period_wrap = 1'b0;
        if (en_auto) begin
            if (period_q == 16'(PERIOD_US - 1)) begin
                period_wrap = 1'b1;
            end else begin
                period_d = period_q + 16'd1;
            end
        end
    end

    // A request landing on the launch cycle survives as a fresh pending request.
    assign pend_d = period_wrap | req_single | (pend_q & ~launch);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        width_d   = width_q;
        launch    = 1'b0;
        vld_d     = 1'b0;
        noecho_d  = 1'b0;
        range_d   = 1'b0;
        echo_us_d = echo_us_q;
        dist_d    = dist_q;

        case (state_q)
            S_IDLE: begin
                // Never launch while the sensor still drives a stale echo.
                if (pend_q && !echo_s_q) begin
                    state_d = S_TRIG;
                    cnt_d   = '0;
                    launch  = 1'b1;
                end
            end
            S_TRIG: begin
                if (cnt_q == 16'(TRIG_US - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_WAIT: begin
                if (echo_rise) begin
                    state_d = S_MEAS;
                    width_d = 16'd1;
                end else if (cnt_q == 16'(WAIT_TO_US - 1)) begin
                    noecho_d = 1'b1;
                    state_d  = S_HOLD;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_MEAS: begin
                if (!echo_s_q) begin
                    state_d = S_CONV;
                end else if (width_q >= 16'(ECHO_MAX_US - 1)) begin
                    range_d = 1'b1;
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    width_d = width_q + 16'd1;
                end
            end
            S_CONV: begin
                // 11239 / 2^16 approximates 0.171494 mm per us of round-trip echo.
                vld_d     = 1'b1;
                echo_us_d = width_q;
                dist_d    = 14'((30'(width_q) * 30'd11239) >> 16);
                state_d   = S_HOLD;
                cnt_d     = '0;
            end
            S_HOLD: begin
                if (cnt_q == 16'(HOLDOFF_US - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        trig_d = (state_d == S_TRIG);
    end

    always_ff @(posedge clk_1m or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            width_q     <= '0;
            period_q    <= '0;
            pend_q      <= 1'b0;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_prev_q <= 1'b0;
            trig_q      <= 1'b0;
            vld_q       <= 1'b0;
            noecho_q    <= 1'b0;
            range_q     <= 1'b0;
            echo_us_q   <= '0;
            dist_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            period_q    <= period_d;
            pend_q      <= pend_d;
            echo_meta_q <= s1_echo;
            echo_s_q    <= echo_meta_q;
            echo_prev_q <= echo_s_q;
            trig_q      <= trig_d;
            vld_q       <= vld_d;
            noecho_q    <= noecho_d;
            range_q     <= range_d;
            echo_us_q   <= echo_us_d;
            dist_q      <= dist_d;
        end
    end

    assign s1_trig    = trig_q;
    assign busy       = (state_q != S_IDLE);
    assign echo_us    = echo_us_q;
    assign dist_mm    = dist_q;
    assign meas_vld   = vld_q;
    assign err_noecho = noecho_q;
    assign err_range  = range_q;

endmodule

// File: tb/tb_sr04_ranger_ctrl.sv
// Self-checking bench for sr04_ranger_ctrl with shortened timing parameters and a
// behavioural sensor that answers each trigger fall with a programmable echo.
module tb_sr04_ranger_ctrl;

    localparam int unsigned TRIG    = 10;
    localparam int unsigned PERIOD  = 8000;
    localparam int unsigned WAITTO  = 300;
    localparam int unsigned EMAX    = 7000;
    localparam int unsigned HOLDOFF = 100;

    logic        clk_1m = 1'b0;
    logic        rst;
    logic        en_auto;
    logic        req_single;
    logic        s1_echo;
    logic        s1_trig;
    logic        busy;
    logic [15:0] echo_us;
    logic [13:0] dist_mm;
    logic        meas_vld;
    logic        err_noecho;
    logic        err_range;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit modelOn    = 1'b0;
    int modelDelay = 50;
    int modelWidth = 1000;
    int echoRiseCyc = 0;
    int echoFallCyc = 0;

    int   trigRises = 0, trigRiseCyc = 0, trigFallCyc = 0, lastTrigWidth = 0;
    int   vldCount = 0, vldCyc = 0, noechoCount = 0, noechoCyc = 0;
    int   rangeCount = 0, rangeCyc = 0, busyFallCyc = 0;
    logic trigPrev = 1'b0, busyPrev = 1'b0;

    typedef struct {
        int unsigned width;
        logic [15:0] expEcho;
        logic [13:0] expDist;
    } vec_t;
    vec_t vecs[5];

    sr04_ranger_ctrl #(
        .TRIG_US    (TRIG),
        .PERIOD_US  (PERIOD),
        .WAIT_TO_US (WAITTO),
        .ECHO_MAX_US(EMAX),
        .HOLDOFF_US (HOLDOFF)
    ) dut (
        .clk_1m    (clk_1m),
        .rst       (rst),
        .en_auto   (en_auto),
        .req_single(req_single),
        .s1_echo   (s1_echo),
        .s1_trig   (s1_trig),
        .busy      (busy),
        .echo_us   (echo_us),
        .dist_mm   (dist_mm),
        .meas_vld  (meas_vld),
        .err_noecho(err_noecho),
        .err_range (err_range)
    );

    always #5 clk_1m = ~clk_1m;

    always @(posedge clk_1m) cyc <= cyc + 1;

    // Event recorder: timestamps every trigger edge, busy fall and result pulse.
    always @(negedge clk_1m) begin
        trigPrev <= s1_trig;
        busyPrev <= busy;
        if (s1_trig === 1'b1 && trigPrev === 1'b0) begin
            trigRises   <= trigRises + 1;
            trigRiseCyc <= cyc;
        end
        if (s1_trig === 1'b0 && trigPrev === 1'b1) begin
            trigFallCyc   <= cyc;
            lastTrigWidth <= cyc - trigRiseCyc;
        end
        if (busy === 1'b0 && busyPrev === 1'b1) busyFallCyc <= cyc;
        if (meas_vld === 1'b1) begin
            vldCount <= vldCount + 1;
            vldCyc   <= cyc;
        end
        if (err_noecho === 1'b1) begin
            noechoCount <= noechoCount + 1;
            noechoCyc   <= cyc;
        end
        if (err_range === 1'b1) begin
            rangeCount <= rangeCount + 1;
            rangeCyc   <= cyc;
        end
    end

    initial begin
        s1_echo = 1'b0;
        forever begin
            @(negedge s1_trig);
            if (modelOn) begin
                repeat (modelDelay) @(negedge clk_1m);
                s1_echo     = 1'b1;
                echoRiseCyc = cyc;
                repeat (modelWidth) @(negedge clk_1m);
                s1_echo     = 1'b0;
                echoFallCyc = cyc;
            end
        end
    end

    task automatic tick();
        @(negedge clk_1m);
        #1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name, input int maxCyc);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got no event within %0d cycles, expected one", name, maxCyc);
    endtask

    task automatic applyStimulus();
        req_single = 1'b1;
        tick();
        req_single = 1'b0;
    endtask

    task automatic waitResult(input int maxCyc, input string name);
        int  start;
        bit  seen;
        start = vldCount + noechoCount + rangeCount;
        seen  = 1'b0;
        for (int i = 0; i < maxCyc && !seen; i++) begin
            tick();
            if (vldCount + noechoCount + rangeCount != start) seen = 1'b1;
        end
        if (!seen) timeoutFail(name, maxCyc);
    endtask

    task automatic waitTrigCount(input int target, input int maxCyc, input string name);
        bit seen;
        seen = (trigRises >= target);
        for (int i = 0; i < maxCyc && !seen; i++) begin
            tick();
            if (trigRises >= target) seen = 1'b1;
        end
        if (!seen) timeoutFail(name, maxCyc);
    endtask

    task automatic waitBusyLow(input int maxCyc, input string name);
        bit seen;
        seen = (busy === 1'b0);
        for (int i = 0; i < maxCyc && !seen; i++) begin
            tick();
            if (busy === 1'b0) seen = 1'b1;
        end
        if (!seen) timeoutFail(name, maxCyc);
    endtask

    task automatic waitHigh(input bit useEcho, input int maxCyc, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCyc && !seen; i++) begin
            tick();
            if ((useEcho ? s1_echo : s1_trig) === 1'b1) seen = 1'b1;
        end
        if (!seen) timeoutFail(name, maxCyc);
    endtask

    initial begin
        int base, vbase, nbase, rbase, t1;

        vecs[0] = '{1000, 16'd1000, 14'd171};
        vecs[1] = '{1,    16'd1,    14'd0};
        vecs[2] = '{100,  16'd100,  14'd17};
        vecs[3] = '{5831, 16'd5831, 14'd999};
        vecs[4] = '{6999, 16'd6999, 14'd1200};

        rst        = 1'b1;
        en_auto    = 1'b0;
        req_single = 1'b0;
        waitCycles(3);
        checkOutput("reset_trig", s1_trig, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_echo_us", echo_us, 0);
        checkOutput("reset_dist_mm", dist_mm, 0);
        checkOutput("reset_meas_vld", meas_vld, 0);
        rst = 1'b0;
        waitCycles(5);

        // Table-driven conversions, including the widest valid echo.
        modelOn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            modelWidth = int'(vecs[i].width);
            vbase = vldCount;
            nbase = noechoCount + rangeCount;
            applyStimulus();
            waitResult(int'(vecs[i].width) + 1000, $sformatf("result_wait[%0d]", i));
            checkOutput($sformatf("vld_count[%0d]", i), vldCount - vbase, 1);
            checkOutput($sformatf("no_err[%0d]", i), noechoCount + rangeCount - nbase, 0);
            checkOutput($sformatf("echo_us[%0d]", i), echo_us, vecs[i].expEcho);
            checkOutput($sformatf("dist_mm[%0d]", i), dist_mm, vecs[i].expDist);
            checkOutput($sformatf("vld_latency[%0d]", i), vldCyc - echoFallCyc, 4);
            checkOutput($sformatf("trig_width[%0d]", i), lastTrigWidth, TRIG);
            waitBusyLow(HOLDOFF + 20, $sformatf("hold_end[%0d]", i));
        end

        // No echo at all: timeout, then holdoff, results untouched.
        modelOn = 1'b0;
        vbase = vldCount;
        nbase = noechoCount;
        applyStimulus();
        waitResult(TRIG + WAITTO + 50, "noecho_wait");
        checkOutput("noecho_count", noechoCount - nbase, 1);
        checkOutput("noecho_no_vld", vldCount - vbase, 0);
        checkOutput("noecho_timing", noechoCyc - trigFallCyc, WAITTO);
        waitBusyLow(HOLDOFF + 20, "noecho_hold");
        checkOutput("noecho_holdoff", busyFallCyc - noechoCyc, HOLDOFF);
        checkOutput("noecho_echo_kept", echo_us, 6999);
        checkOutput("noecho_dist_kept", dist_mm, 1200);

        // Over-long echo: range error, then the next trigger waits for the echo to drop.
        modelOn    = 1'b1;
        modelWidth = 9000;
        vbase = vldCount;
        rbase = rangeCount;
        applyStimulus();
        waitResult(9500, "range_wait");
        checkOutput("range_count", rangeCount - rbase, 1);
        checkOutput("range_no_vld", vldCount - vbase, 0);
        checkOutput("range_timing", rangeCyc - echoRiseCyc, EMAX + 2);
        checkOutput("range_echo_kept", echo_us, 6999);
        checkOutput("range_dist_kept", dist_mm, 1200);
        waitBusyLow(HOLDOFF + 20, "range_hold");
        checkOutput("range_holdoff", busyFallCyc - rangeCyc, HOLDOFF);
        modelWidth = 500;
        base = trigRises;
        applyStimulus();
        waitTrigCount(base + 1, 3000, "stale_echo_trig");
        checkOutput("stale_echo_gate", trigRiseCyc - echoFallCyc, 3);
        waitResult(1500, "after_stale_wait");
        checkOutput("after_stale_echo", echo_us, 500);
        checkOutput("after_stale_dist", dist_mm, 85);
        waitBusyLow(HOLDOFF + 20, "after_stale_hold");

        // Auto mode: fixed trigger spacing, then drop en_auto during MEAS.
        modelWidth = 5800;
        base  = trigRises;
        vbase = vldCount;
        en_auto = 1'b1;
        waitTrigCount(base + 1, PERIOD + 100, "auto_trig1");
        t1 = trigRiseCyc;
        waitResult(6500, "auto_meas1");
        checkOutput("auto_echo1", echo_us, 5800);
        checkOutput("auto_dist1", dist_mm, 994);
        waitTrigCount(base + 2, PERIOD, "auto_trig2");
        checkOutput("auto_period", trigRiseCyc - t1, PERIOD);
        waitCycles(1100);
        en_auto = 1'b0;
        waitResult(6000, "auto_meas2");
        checkOutput("auto_dist2", dist_mm, 994);
        checkOutput("auto_vld_count", vldCount - vbase, 2);
        waitBusyLow(HOLDOFF + 20, "auto_hold");
        base = trigRises;
        waitCycles(PERIOD + 500);
        checkOutput("auto_off_no_trig", trigRises - base, 0);

        // Three requests during MEAS/HOLD merge into one extra trigger.
        modelWidth = 1000;
        base  = trigRises;
        vbase = vldCount;
        applyStimulus();
        waitHigh(1'b1, 200, "merge_echo_high");
        waitCycles(100);
        applyStimulus();
        waitCycles(100);
        applyStimulus();
        waitResult(2000, "merge_meas1");
        waitCycles(20);
        applyStimulus();
        waitCycles(2000);
        checkOutput("merge_trig_count", trigRises - base, 2);
        checkOutput("merge_vld_count", vldCount - vbase, 2);
        checkOutput("merge_echo", echo_us, 1000);

        // Reset in TRIG, then in MEAS: outputs clear at once, no trigger afterwards.
        modelOn = 1'b0;
        applyStimulus();
        waitHigh(1'b0, 20, "rst_trig_high");
        waitCycles(3);
        rst = 1'b1;
        #1;
        checkOutput("rst_trig_trig", s1_trig, 0);
        checkOutput("rst_trig_busy", busy, 0);
        checkOutput("rst_trig_echo", echo_us, 0);
        tick();
        rst  = 1'b0;
        base = trigRises;
        waitCycles(200);
        checkOutput("rst_trig_no_retrig", trigRises - base, 0);

        modelOn    = 1'b1;
        modelWidth = 300;
        applyStimulus();
        waitResult(1000, "rst_pre_meas");
        checkOutput("rst_pre_echo", echo_us, 300);
        checkOutput("rst_pre_dist", dist_mm, 51);
        waitBusyLow(HOLDOFF + 20, "rst_pre_hold");
        modelWidth = 1000;
        applyStimulus();
        waitHigh(1'b1, 200, "rst_meas_echo_high");
        waitCycles(100);
        rst = 1'b1;
        #1;
        checkOutput("rst_meas_echo", echo_us, 0);
        checkOutput("rst_meas_dist", dist_mm, 0);
        checkOutput("rst_meas_busy", busy, 0);
        checkOutput("rst_meas_trig", s1_trig, 0);
        tick();
        tick();
        rst   = 1'b0;
        base  = trigRises;
        vbase = vldCount;
        waitCycles(1200);
        checkOutput("rst_meas_no_retrig", trigRises - base, 0);
        checkOutput("rst_meas_no_vld", vldCount - vbase, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
